// File: rtl/nor_gate_checker_pkg.sv
// Shared types and constants for the NOR gate checker: FSM states, widths and
// the expected NOR truth table indexed by vector number.
package nor_gate_checker_pkg;

   localparam int unsigned IDX_W   = 2;
   localparam int unsigned ERR_W   = 3;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned NUM_VEC = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   // Bit idx holds the expected gate output for vector idx = {in0, in1}
   localparam logic [NUM_VEC-1:0] EXP_OUT = 4'b0001;

   localparam logic [ERR_W-1:0] ERR_MAX = 3'd4;

endpackage

// File: rtl/nor_gate_checker_settle_cnt.sv
// Loadable down counter that times how long each vector settles before sampling.
module nor_gate_checker_settle_cnt
   import nor_gate_checker_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero_c
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - CNT_W'(1);
      end
   end

   assign zero_c = (count == '0);

endmodule

// File: rtl/nor_gate_checker.sv
// Drives the four 2-input vectors into an external gate, samples its output
// after SETTLE cycles per vector and reports mismatches against NOR.
module nor_gate_checker
   import nor_gate_checker_pkg::*;
#(
   parameter int unsigned SETTLE = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             dut_out,
   output logic             dut_in0,
   output logic             dut_in1,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [IDX_W-1:0] first_err_idx
);

   // Counter is loaded with SETTLE-1 so DRIVE lasts exactly SETTLE edges
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             in0_d, in1_d;
   logic             busy_d, done_d, pass_d;
   logic [ERR_W-1:0] err_d;
   logic [IDX_W-1:0] first_d;
   logic             cnt_load, cnt_dec, cnt_zero;
   logic             mismatch;

   nor_gate_checker_settle_cnt u_settle_cnt (
      .clk      (clk),
      .rst_n    (reset),
      .load     (cnt_load),
      .load_val (SETTLE_LOAD),
      .dec      (cnt_dec),
      .zero_c   (cnt_zero)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: if (start) state_d = DRIVE;
         DRIVE:      if (cnt_zero) state_d = SAMPLE;
         SAMPLE:     state_d = (idx_q == IDX_W'(NUM_VEC - 1)) ? DONE : DRIVE;
         default:    state_d = IDLE;
      endcase
   end

   // Next values for the registered outputs and datapath
   always_comb begin
      idx_d    = idx_q;
      in0_d    = dut_in0;
      in1_d    = dut_in1;
      busy_d   = busy;
      done_d   = done;
      pass_d   = pass;
      err_d    = err_count;
      first_d  = first_err_idx;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      mismatch = (dut_out != EXP_OUT[idx_q]);
      case (state_q)
         IDLE, DONE: begin
            in0_d = 1'b0;
            in1_d = 1'b0;
            if (start) begin
               idx_d    = '0;
               err_d    = '0;
               first_d  = '0;
               done_d   = 1'b0;
               pass_d   = 1'b0;
               busy_d   = 1'b1;
               cnt_load = 1'b1;
            end
         end
         DRIVE: begin
            if (!cnt_zero) cnt_dec = 1'b1;
         end
         SAMPLE: begin
            if (mismatch && (err_count != ERR_MAX)) begin
               err_d = err_count + ERR_W'(1);
               if (err_count == '0) first_d = idx_q;
            end
            if (idx_q == IDX_W'(NUM_VEC - 1)) begin
               busy_d = 1'b0;
               done_d = 1'b1;
               pass_d = (err_d == '0);
               in0_d  = 1'b0;
               in1_d  = 1'b0;
            end else begin
               idx_d    = idx_q + IDX_W'(1);
               in0_d    = idx_d[1];
               in1_d    = idx_d[0];
               cnt_load = 1'b1;
            end
         end
         default: begin
            in0_d = 1'b0;
            in1_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx_q         <= '0;
         dut_in0       <= 1'b0;
         dut_in1       <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b0;
         err_count     <= '0;
         first_err_idx <= '0;
      end else begin
         idx_q         <= idx_d;
         dut_in0       <= in0_d;
         dut_in1       <= in1_d;
         busy          <= busy_d;
         done          <= done_d;
         pass          <= pass_d;
         err_count     <= err_d;
         first_err_idx <= first_d;
      end
   end

endmodule

// File: tb/tb_nor_gate_checker.sv
// Bench for nor_gate_checker: SETTLE=1 and SETTLE=3 instances share stimulus;
// run results are checked through per-instance expectation queues.
module tb_nor_gate_checker;

   typedef struct {
      logic [1:0] mode;   // 0 NOR, 1 tied 0, 2 OR, 3 ~in0
      logic [2:0] err;
      logic [1:0] first;
      logic       pass;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [1:0] mode;

   logic       out1, a0_1, a1_1, busy1, done1, pass1;
   logic [2:0] err1;
   logic [1:0] fe1;
   logic       out3, a0_3, a1_3, busy3, done3, pass3;
   logic [2:0] err3;
   logic [1:0] fe3;

   int n_cmp = 0;
   int n_bad = 0;

   vec_t exp_q1[$];
   vec_t exp_q3[$];
   vec_t vecs[4];
   vec_t e1, e3;
   logic prev1 = 1'b0;
   logic prev3 = 1'b0;

   always #5 clk = ~clk;

   function automatic logic model(input logic [1:0] m, input logic a, input logic b);
      case (m)
         2'd0:    return ~(a | b);
         2'd1:    return 1'b0;
         2'd2:    return a | b;
         default: return ~a;
      endcase
   endfunction

   assign out1 = model(mode, a0_1, a1_1);
   assign out3 = model(mode, a0_3, a1_3);

   nor_gate_checker #(.SETTLE(1)) u1 (
      .clk(clk), .reset(reset), .start(start), .dut_out(out1),
      .dut_in0(a0_1), .dut_in1(a1_1), .busy(busy1), .done(done1),
      .pass(pass1), .err_count(err1), .first_err_idx(fe1)
   );

   nor_gate_checker #(.SETTLE(3)) u3 (
      .clk(clk), .reset(reset), .start(start), .dut_out(out3),
      .dut_in0(a0_3), .dut_in1(a1_3), .busy(busy3), .done(done3),
      .pass(pass3), .err_count(err3), .first_err_idx(fe3)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: each rising done pops the expectation pushed at start
   always @(negedge clk) begin
      if (done1 && !prev1) begin
         if (exp_q1.size() == 0) chk("u1 unexpected done", 1, 0);
         else begin
            e1 = exp_q1.pop_front();
            chk("u1 err_count", int'(err1), int'(e1.err));
            chk("u1 pass", int'(pass1), int'(e1.pass));
            if (e1.err != 3'd0) chk("u1 first_err_idx", int'(fe1), int'(e1.first));
         end
      end
      prev1 <= done1;
   end

   always @(negedge clk) begin
      if (done3 && !prev3) begin
         if (exp_q3.size() == 0) chk("u3 unexpected done", 1, 0);
         else begin
            e3 = exp_q3.pop_front();
            chk("u3 err_count", int'(err3), int'(e3.err));
            chk("u3 pass", int'(pass3), int'(e3.pass));
            if (e3.err != 3'd0) chk("u3 first_err_idx", int'(fe3), int'(e3.first));
         end
      end
      prev3 <= done3;
   end

   // One start pulse; walks both instances through their full runs
   task automatic run(input vec_t v);
      mode = v.mode;
      @(negedge clk);
      start = 1'b1;
      exp_q1.push_back(v);
      exp_q3.push_back(v);
      @(posedge clk);
      #1 start = 1'b0;
      for (int c = 0; c <= 16; c++) begin
         if (c < 8) begin
            chk("u1 busy in run", int'(busy1), 1);
            chk("u1 done in run", int'(done1), 0);
            chk("u1 vector", int'({a0_1, a1_1}), c / 2);
         end else if (c == 8) begin
            chk("u1 done at 8", int'(done1), 1);
            chk("u1 busy at 8", int'(busy1), 0);
            chk("u1 idle vector", int'({a0_1, a1_1}), 0);
         end
         if (c < 16) begin
            chk("u3 busy in run", int'(busy3), 1);
            chk("u3 done in run", int'(done3), 0);
            chk("u3 vector", int'({a0_3, a1_3}), c / 4);
            @(posedge clk);
            #1;
         end else begin
            chk("u3 done at 16", int'(done3), 1);
            chk("u3 busy at 16", int'(busy3), 0);
            chk("u1 done held", int'(done1), 1);
            chk("u1 err held", int'(err1), int'(v.err));
         end
      end
   endtask

   initial begin
      vecs[0] = '{mode: 2'd0, err: 3'd0, first: 2'd0, pass: 1'b1};
      vecs[1] = '{mode: 2'd1, err: 3'd1, first: 2'd0, pass: 1'b0};
      vecs[2] = '{mode: 2'd2, err: 3'd4, first: 2'd0, pass: 1'b0};
      vecs[3] = '{mode: 2'd3, err: 3'd1, first: 2'd1, pass: 1'b0};

      reset = 1'b0;
      start = 1'b0;
      mode  = 2'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("u1 reset outputs", int'({busy1, done1, pass1, err1, fe1, a0_1, a1_1}), 0);
      chk("u3 reset outputs", int'({busy3, done3, pass3, err3, fe3, a0_3, a1_3}), 0);
      @(negedge clk) reset = 1'b1;
      @(posedge clk);
      #1 chk("u1 idle after reset", int'({busy1, done1, a0_1, a1_1}), 0);

      for (int i = 0; i < 4; i++) run(vecs[i]);

      // Start held high: no restart mid-run, restart only from DONE with counts cleared
      mode = 2'd2;
      @(negedge clk);
      start = 1'b1;
      exp_q1.push_back(vecs[2]);
      exp_q1.push_back(vecs[2]);
      exp_q3.push_back(vecs[2]);
      @(posedge clk);
      #1;
      for (int c = 0; c <= 17; c++) begin
         if (c == 4) begin
            chk("held u1 busy", int'(busy1), 1);
            chk("held u1 no restart", int'({a0_1, a1_1}), 2);
         end
         if (c == 8) chk("held u1 done", int'(done1), 1);
         if (c == 9) begin
            chk("held u1 restarted", int'(busy1), 1);
            chk("held u1 done cleared", int'(done1), 0);
            chk("held u1 err cleared", int'(err1), 0);
         end
         if (c == 16) begin
            chk("held u3 done", int'(done3), 1);
            start = 1'b0;
         end
         if (c == 17) begin
            chk("held u1 second done", int'(done1), 1);
            chk("held u3 stays done", int'({busy3, done3}), 1);
         end
         if (c < 17) begin
            @(posedge clk);
            #1;
         end
      end

      // Asynchronous reset during vector 2 of the SETTLE=1 instance
      mode = 2'd0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #3;
      chk("u1 in vector 2", int'({a0_1, a1_1}), 2);
      reset = 1'b0;
      #1;
      chk("u1 async reset", int'({busy1, done1, pass1, err1, fe1, a0_1, a1_1}), 0);
      chk("u3 async reset", int'({busy3, done3, pass3, err3, fe3, a0_3, a1_3}), 0);
      start = 1'b1;
      @(posedge clk);
      #1 chk("start ignored in reset", int'(busy1), 0);
      start = 1'b0;
      @(negedge clk) reset = 1'b1;
      run(vecs[0]);

      repeat (3) @(posedge clk);
      chk("u1 queue drained", exp_q1.size(), 0);
      chk("u3 queue drained", exp_q3.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/nor_gate_checker.md
NOR_GATE_CHECKER -- requirements
Module: nor_gate_checker

Interface
REQ-001 SHALL have parameter: SETTLE, default 1, number of cycles each test vector is driven before dut_out is sampled (legal range 1..15).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 SHALL have port: start  input  1  request a new 4-vector test run.
REQ-005 SHALL have port: dut_out  input  1  output of the external 2-input gate under test.
REQ-006 SHALL have port: dut_in0  output  1  first operand driven to the gate under test.
REQ-007 SHALL have port: dut_in1  output  1  second operand driven to the gate under test.
REQ-008 SHALL have port: busy  output  1  high while a run is in progress.
REQ-009 SHALL have port: done  output  1  high once a run has completed, until the next run starts.
REQ-010 SHALL have port: pass  output  1  high when done=1 and err_count=0.
REQ-011 SHALL have port: err_count  output  3  number of mismatching vectors in the current or last run (0..4).
REQ-012 SHALL have port: first_err_idx  output  2  index of the first mismatching vector; meaningful only when err_count!=0.

Function
REQ-013 SHALL implement FSM states IDLE, DRIVE, SAMPLE, DONE; all outputs registered.
REQ-014 SHALL apply vectors in order idx 0..3 with dut_in0=idx[1], dut_in1=idx[0], i.e. (0,0),(0,1),(1,0),(1,1); expected outputs 1,0,0,0 (NOR).
REQ-015 SHALL, in IDLE or DONE, on an edge with start=1: go to DRIVE, set idx=0, clear err_count and first_err_idx, clear done/pass, set busy=1.
REQ-016 SHALL remain in DRIVE for exactly SETTLE edges, then go to SAMPLE for exactly one edge.
REQ-017 SHALL, on the SAMPLE edge, compare dut_out with NOR(dut_in0,dut_in1); on mismatch, increment err_count and, if err_count was 0, load first_err_idx=idx.
REQ-018 SHALL, after SAMPLE, go to DRIVE with idx+1 if idx<3, otherwise to DONE with busy=0, done=1, pass=(final err_count==0).
REQ-019 SHALL hold dut_in0/dut_in1 stable across all DRIVE and SAMPLE cycles of a vector, and drive 0/0 in IDLE and DONE.
REQ-020 SHALL assert done exactly 4*(SETTLE+1) edges after the edge that accepted start (8 edges for SETTLE=1).
REQ-021 SHALL ignore start while busy=1 (no restart, no effect on counts).
REQ-022 SHALL hold done, pass, err_count, first_err_idx stable in DONE until a new start is accepted.
REQ-023 SHALL never wrap err_count (maximum value 4 fits 3 bits).

Reset
REQ-024 SHALL on reset=0 immediately force state IDLE, idx=0, settle counter 0, dut_in0=dut_in1=0, busy=0, done=0, pass=0, err_count=0, first_err_idx=0, including mid-run.
REQ-025 SHALL not accept start until the first rising edge after reset returns to 1.

Structure
REQ-026 SHALL place the FSM state enum typedef and the 4-entry expected-output constant in a shared package nor_gate_checker_pkg.
REQ-027 SHALL implement the settle wait in one sub-module nor_gate_checker_settle_cnt (loadable 4-bit down counter with zero flag).

Verification
REQ-028 SHALL cover: correct NOR model on dut_out, SETTLE=1, start pulse -> busy for 8 cycles, done=1, pass=1, err_count=0.
REQ-029 SHALL cover: dut_out tied 0 -> done=1, pass=0, err_count=1, first_err_idx=0.
REQ-030 SHALL cover: OR model on dut_out -> err_count=4, first_err_idx=0; inverter-of-in0 model (dut_out=~in0) -> err_count=1, first_err_idx=1.
REQ-031 SHALL cover: SETTLE=3, correct model -> done exactly 16 edges after start accepted; dut_in stable 4 cycles per vector.
REQ-032 SHALL cover: start held high throughout run -> single run, second run begins only from DONE, counts cleared on restart.
REQ-033 SHALL cover: reset=0 asserted during vector 2 -> all outputs 0 without waiting for clk; fresh start afterwards -> normal 8-cycle pass run.
